// File: rtl/spi_flash_resp.sv
// spi_flash_resp: SPI mode-0 flash responder. It decodes READ (0x03) plus a 24-bit byte
// address and streams little-endian bytes from a 32-bit word memory, prefetching one word ahead.
// All SPI pins are oversampled on clk through synchronizers.
// Optional feature macro: SPI_FLASH_FAST_READ_EN also accepts FAST READ (0x0B) with 8 dummy clocks.
module spi_flash_resp #(
  parameter int unsigned ADDR_W      = 22,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              spi_clk,
  input  logic              spi_cs,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [31:0]       mem_rdata,
  output logic              busy,
  output logic              cmd_err
);

  localparam int unsigned CNT_W   = 5;
  localparam logic [7:0]  OP_READ = 8'h03;
`ifdef SPI_FLASH_FAST_READ_EN
  localparam logic [7:0]  OP_FAST_READ = 8'h0B;
`endif

  typedef enum logic [2:0] {
    ST_IDLE, ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA, ST_IGNORE
  } state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   sclk_prev, cs_prev;
  logic                   rise, fall, cs_fall;

  logic [CNT_W-1:0]  bit_cnt;
  logic [6:0]        cmd_sh;
  logic [22:0]       addr_sh;
  logic [23:0]       addr_full;
  logic [7:0]        opcode;
  logic              fast_q;
  logic              adv_q;
  logic [1:0]        offset, offset_inc, src_off;
  logic [2:0]        bit_inc;
  logic [ADDR_W-1:0] waddr;
  logic [31:0]       cur_word, pf_word, src_word;
  logic              ren_cur, rd_cur_v, rd_pf_v;

  logic abort_c, err_c, fast_c, start_rd_c;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign rise      = sclk_s & ~sclk_prev;
  assign fall      = ~sclk_s & sclk_prev;
  assign cs_fall   = cs_prev & ~cs_s;
  assign opcode    = {cmd_sh, mosi_s};
  assign addr_full = {addr_sh, mosi_s};

  // Byte-advance helpers: on a byte boundary the next bit comes from the next byte (or prefetch word)
  assign offset_inc = offset + 2'd1;
  assign bit_inc    = bit_cnt[2:0] + 3'd1;
  assign src_word   = (adv_q && offset == 2'd3) ? pf_word : cur_word;
  assign src_off    = adv_q ? offset_inc : offset;

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Next-state decode and single-cycle control strobes
  always_comb begin
    state_nxt  = state;
    abort_c    = 1'b0;
    err_c      = 1'b0;
    fast_c     = 1'b0;
    start_rd_c = 1'b0;
    if (state != ST_IDLE && cs_s) begin
      abort_c   = 1'b1;
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (cs_fall) state_nxt = ST_CMD;
        ST_CMD: begin
          if (rise && bit_cnt == CNT_W'(7)) begin
            if (opcode == OP_READ) begin
              state_nxt = ST_ADDR;
`ifdef SPI_FLASH_FAST_READ_EN
            end else if (opcode == OP_FAST_READ) begin
              state_nxt = ST_ADDR;
              fast_c    = 1'b1;
`endif
            end else begin
              state_nxt = ST_IGNORE;
              err_c     = 1'b1;
            end
          end
        end
        ST_ADDR: begin
          if (rise && bit_cnt == CNT_W'(23)) begin
            start_rd_c = 1'b1;
            state_nxt  = fast_q ? ST_DUMMY : ST_DATA;
          end
        end
        ST_DUMMY:  if (rise && bit_cnt == CNT_W'(7)) state_nxt = ST_DATA;
        ST_DATA:   state_nxt = ST_DATA;
        ST_IGNORE: state_nxt = ST_IGNORE;
        default:   state_nxt = ST_IDLE;
      endcase
    end
  end

  // Pin synchronizers, shifters, word fetch/prefetch and MISO driver
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      sclk_prev <= 1'b0;
      cs_prev   <= 1'b0;
      spi_miso  <= 1'b1;
      mem_ren   <= 1'b0;
      mem_raddr <= '0;
      busy      <= 1'b0;
      cmd_err   <= 1'b0;
      bit_cnt   <= '0;
      cmd_sh    <= '0;
      addr_sh   <= '0;
      fast_q    <= 1'b0;
      adv_q     <= 1'b0;
      offset    <= '0;
      waddr     <= '0;
      cur_word  <= '0;
      pf_word   <= '0;
      ren_cur   <= 1'b0;
      rd_cur_v  <= 1'b0;
      rd_pf_v   <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      sclk_prev <= sclk_s;
      cs_prev   <= cs_s;
      cmd_err   <= err_c;
      busy      <= (state_nxt != ST_IDLE);
      mem_ren   <= 1'b0;
      rd_cur_v  <= mem_ren & ren_cur;
      rd_pf_v   <= mem_ren & ~ren_cur;

      if (abort_c || state == ST_IDLE) begin
        spi_miso <= 1'b1;
        bit_cnt  <= '0;
        adv_q    <= 1'b0;
        fast_q   <= 1'b0;
        rd_cur_v <= 1'b0;
        rd_pf_v  <= 1'b0;
      end else begin
        // First word arrives: keep it and immediately prefetch the following word
        if (rd_cur_v) begin
          cur_word  <= mem_rdata;
          mem_ren   <= 1'b1;
          ren_cur   <= 1'b0;
          mem_raddr <= waddr + ADDR_W'(1);
        end
        if (rd_pf_v) pf_word <= mem_rdata;

        case (state)
          ST_CMD: begin
            if (rise) begin
              cmd_sh  <= opcode[6:0];
              bit_cnt <= (bit_cnt == CNT_W'(7)) ? '0 : bit_cnt + CNT_W'(1);
              fast_q  <= fast_c;
            end
          end
          ST_ADDR: begin
            if (rise) begin
              addr_sh <= addr_full[22:0];
              bit_cnt <= bit_cnt + CNT_W'(1);
              if (start_rd_c) begin
                bit_cnt   <= '0;
                mem_ren   <= 1'b1;
                ren_cur   <= 1'b1;
                mem_raddr <= addr_full[ADDR_W+1:2];
                waddr     <= addr_full[ADDR_W+1:2];
                offset    <= addr_full[1:0];
                adv_q     <= 1'b0;
              end
            end
          end
          ST_DUMMY: begin
            if (rise) bit_cnt <= (bit_cnt == CNT_W'(7)) ? '0 : bit_cnt + CNT_W'(1);
          end
          ST_DATA: begin
            // Byte advance is lazy: it happens on the fall that needs the next byte's bit 7
            if (fall) begin
              spi_miso <= src_word[{src_off, ~bit_cnt[2:0]}];
              bit_cnt  <= {2'b00, bit_inc};
              adv_q    <= (bit_cnt[2:0] == 3'd7);
              if (adv_q) begin
                offset <= offset_inc;
                if (offset == 2'd3) begin
                  cur_word  <= pf_word;
                  waddr     <= waddr + ADDR_W'(1);
                  mem_ren   <= 1'b1;
                  ren_cur   <= 1'b0;
                  mem_raddr <= waddr + ADDR_W'(2);
                end
              end
            end
          end
          default: spi_miso <= 1'b1;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_resp.sv
// tb_spi_flash_resp: randomized SPI master driving spi_flash_resp against a byte-stream reference model.
module tb_spi_flash_resp;

  localparam int unsigned ADDR_W      = 22;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned SPI_HALF    = 5;

  logic              clk = 1'b0;
  logic              resetn;
  logic              spi_clk, spi_cs, spi_mosi, spi_miso;
  logic              mem_ren, busy, cmd_err;
  logic [ADDR_W-1:0] mem_raddr;
  logic [31:0]       mem_rdata;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned ren_cnt  = 0;
  int unsigned err_cnt  = 0;
  int unsigned ren_addr_q[$];
  logic [31:0] mem_ovr [int unsigned];

  spi_flash_resp #(.ADDR_W(ADDR_W), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .resetn(resetn), .spi_clk(spi_clk), .spi_cs(spi_cs), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .busy(busy), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  // Memory content: explicit overrides, otherwise a fixed hash of the word address
  function automatic logic [31:0] word_of(input logic [ADDR_W-1:0] wa);
    if (mem_ovr.exists(32'(wa))) return mem_ovr[32'(wa)];
    return (32'(wa) * 32'h9E37_79B1) ^ 32'hA5C3_0F96;
  endfunction

  // Reference: byte at any byte address, little-endian within each word
  function automatic logic [7:0] exp_byte(input logic [23:0] a);
    logic [31:0] w;
    w = word_of(a[ADDR_W+1:2]) >> (8 * int'(a[1:0]));
    return w[7:0];
  endfunction

  // Memory with one-clk read latency; garbage on non-read cycles
  always @(posedge clk) begin
    mem_rdata <= mem_ren ? word_of(mem_raddr) : $urandom();
    if (mem_ren) begin
      ren_cnt++;
      ren_addr_q.push_back(32'(mem_raddr));
    end
    if (cmd_err) err_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One mode-0 bit: falling edge + MOSI setup, sample MISO, rising edge; leaves spi_clk high
  task automatic spi_bit(input logic mosi_v, output logic miso_v);
    spi_clk  = 1'b0;
    spi_mosi = mosi_v;
    wait_clks(SPI_HALF);
    miso_v  = spi_miso;
    spi_clk = 1'b1;
    wait_clks(SPI_HALF);
  endtask

  // Raise cs while spi_clk is still high, so the trailing fall lands after deselect
  task automatic end_cs();
    spi_cs = 1'b1;
    wait_clks(SPI_HALF);
    spi_clk = 1'b0;
    wait_clks(2 * SPI_HALF);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_miso", 32'(spi_miso), 32'd1);
  endtask

  task automatic send_byte(input logic [7:0] v);
    logic m;
    for (int i = 7; i >= 0; i--) spi_bit(v[i], m);
  endtask

  task automatic do_read(input logic [7:0] op, input logic [23:0] a,
                         input int unsigned ndummy, input int unsigned nbytes);
    logic        m;
    logic [7:0]  b;
    int unsigned ren0, q0, first_w, last_w, nw;
    ren0 = ren_cnt;
    q0   = ren_addr_q.size();
    spi_cs = 1'b0;
    wait_clks(4);
    send_byte(op);
    for (int i = 23; i >= 0; i--) spi_bit(a[i], m);
    for (int i = 0; i < int'(ndummy); i++) begin
      spi_bit(1'($urandom), m);
      check("dummy_miso", 32'(m), 32'd1);
    end
    for (int k = 0; k < int'(nbytes); k++) begin
      b = '0;
      for (int i = 0; i < 8; i++) begin
        spi_bit(1'($urandom), m);
        b = {b[6:0], m};
      end
      check($sformatf("rd_byte@%06h", 24'(a + 24'(k))), 32'(b), 32'(exp_byte(24'(a + 24'(k)))));
    end
    end_cs();
    first_w = int'(a) >> 2;
    last_w  = (int'(a) + nbytes - 1) >> 2;
    nw      = last_w - first_w + 2;
    check("ren_count", ren_cnt - ren0, nw);
    for (int unsigned k = 0; k < nw && q0 + k < ren_addr_q.size(); k++)
      check("ren_addr", ren_addr_q[q0 + k], (first_w + k) % (32'd1 << ADDR_W));
  endtask

  // Unsupported opcode: one cmd_err pulse, MISO stays high, no reads
  task automatic do_bad_op(input logic [7:0] op);
    logic        m, acc;
    int unsigned ren0, err0;
    ren0 = ren_cnt;
    err0 = err_cnt;
    acc  = 1'b1;
    spi_cs = 1'b0;
    wait_clks(4);
    for (int i = 7; i >= 0; i--) begin
      spi_bit(op[i], m);
      acc &= m;
    end
    for (int i = 0; i < 32; i++) begin
      spi_bit(1'($urandom), m);
      acc &= m;
    end
    check("ign_busy", 32'(busy), 32'd1);
    end_cs();
    check("ign_miso", 32'(acc), 32'd1);
    check("ign_err_pulses", err_cnt - err0, 32'd1);
    check("ign_ren", ren_cnt - ren0, 32'd0);
  endtask

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        m;
    logic [23:0] ra;
    int unsigned ren0;

    resetn = 1'b0; spi_clk = 1'b0; spi_cs = 1'b1; spi_mosi = 1'b0;
    wait_clks(3);
    check("rst_miso", 32'(spi_miso), 32'd1);
    check("rst_ren", 32'(mem_ren), 32'd0);
    check("rst_raddr", 32'(mem_raddr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cmd_err", 32'(cmd_err), 32'd0);
    resetn = 1'b1;
    wait_clks(5);

    // Aligned word read
    mem_ovr[0] = 32'h1234_5678;
    do_read(8'h03, 24'h000000, 0, 4);

    // Start at offset 2, crossing into the next word
    mem_ovr[1] = 32'hAABB_CCDD;
    do_read(8'h03, 24'h000002, 0, 6);

    // Top-of-memory wrap
    mem_ovr[(32'd1 << ADDR_W) - 1] = 32'hCAFE_F00D;
    mem_ovr[0] = 32'h1122_3344;
    do_read(8'h03, 24'hFFFFFC, 0, 8);
    mem_ovr[0] = 32'h1234_5678;

    // Start at offset 3: one byte from the first word
    do_read(8'h03, 24'h000103, 0, 5);

    // Unsupported opcode, then a normal read
    do_bad_op(8'h9F);
    do_read(8'h03, 24'h000000, 0, 4);

    // Deselect mid-address: back to idle quickly, no read issued
    ren0 = ren_cnt;
    spi_cs = 1'b0;
    wait_clks(4);
    send_byte(8'h03);
    for (int i = 0; i < 12; i++) spi_bit(1'($urandom), m);
    spi_cs = 1'b1;
    wait_clks(SYNC_STAGES + 2);
    check("abort_busy", 32'(busy), 32'd0);
    spi_clk = 1'b0;
    wait_clks(2 * SPI_HALF);
    check("abort_ren", ren_cnt - ren0, 32'd0);
    do_read(8'h03, 24'h000006, 0, 3);

    // Randomized reads
    for (int t = 0; t < 8; t++) begin
      ra = (t % 3 == 0) ? 24'($urandom_range(32'hFFFFF0, 32'hFFFFFF)) : 24'($urandom);
      do_read(8'h03, ra, 0, $urandom_range(1, 9));
    end

    // Reset asserted mid-data while MISO is driving a 0
    spi_cs = 1'b0;
    wait_clks(4);
    send_byte(8'h03);
    for (int i = 0; i < 24; i++) spi_bit(1'b0, m);
    spi_bit(1'b0, m);
    check("pre_rst_bit", 32'(m), 32'd0);
    check("pre_rst_busy", 32'(busy), 32'd1);
    resetn = 1'b0;
    #1;
    check("mid_rst_miso", 32'(spi_miso), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    wait_clks(2);
    spi_cs = 1'b1;
    wait_clks(3);
    spi_clk = 1'b0;
    wait_clks(3);
    resetn = 1'b1;
    wait_clks(6);
    check("post_rst_busy", 32'(busy), 32'd0);
    do_read(8'h03, 24'h000000, 0, 4);

`ifdef SPI_FLASH_FAST_READ_EN
    do_read(8'h0B, 24'h000000, 8, 4);
    do_read(8'h0B, 24'($urandom), 8, 6);
`else
    do_bad_op(8'h0B);
`endif
    do_read(8'h03, 24'h000002, 0, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
